univ_shift_reg_seq: RTL and testbench
=====================================

// Module: univ_shift_reg_seq
// PURPOSE
//  Parametrised universal shift register with a command handshake and step sequencer.
//  One accepted command performs a hold, load, clear, or a multi-step shift/rotate of cmd_count bits, one bit per clock.
//  Sits in the Register_Counters library as the next-generation universal shift register.
//  Serves serialisers and barrel-shift emulation that need N-bit moves and a completion signal.
// PARAMETERS
//  WIDTH  8  register width in bits; must be >= 2
//  CNT_W  4  width of cmd_count; must satisfy 2**CNT_W > WIDTH
// PORTS
//  CLK        in   1        clock; all state updates on the rising edge
//  Clr_b      in   1        reset, asynchronous, active-low
//  cmd_valid  in   1        command request
//  cmd_ready  out  1        high while IDLE; a command is accepted when cmd_valid && cmd_ready at a rising edge
//  cmd_mode   in   3        000 hold, 001 shift right, 010 shift left, 011 parallel load,
//                           100 rotate right, 101 rotate left, 110 arithmetic shift right, 111 sync clear
//  cmd_count  in   CNT_W    number of steps for shift/rotate modes; ignored for other modes
//  I_par      in   WIDTH    parallel load data, sampled on the accept edge
//  MSB_in     in   1        serial input entering bit WIDTH-1 on shift right; sampled on every step edge
//  LSB_in     in   1        serial input entering bit 0 on shift left; sampled on every step edge
//  abort      in   1        synchronous cancel of a running command
//  A_par      out  WIDTH    register contents
//  sout_r     out  1        A_par[0]; combinational from the register
//  sout_l     out  1        A_par[WIDTH-1]; combinational from the register
//  busy       out  1        high in RUN (equals ~cmd_ready)
//  done       out  1        registered one-cycle completion pulse
// BEHAVIOUR
//  Reset (Clr_b low, immediate, also mid-command):
//   - A_par=0, state=IDLE, remaining=0, done=0.
//   - Consequently cmd_ready=1 and busy=0.
//  States and transitions: IDLE and RUN.
//   - IDLE: accept edge applies the first operation.
//   - Hold, load, clear, or count=0: go to IDLE, with done=1 during the next cycle.
//   - Count 1: apply 1 step, go to IDLE, with done=1 during the next cycle.
//   - Count k>1: apply step 1, set remaining=k-1, go to RUN.
//  RUN:
//   - Each edge applies one step and decrements remaining.
//   - The edge that brings remaining to 0 returns to IDLE; done=1 the following cycle.
//  Latency: for k steps, A_par changes on edges 1..k (edge 1 = accept edge); done is high during cycle k+1.
//   - A new command may be accepted in the same cycle that done is high.
//  Count handling: cmd_count > WIDTH is clamped to WIDTH. Rotating by WIDTH leaves A_par unchanged.
//  Shift/rotate step definitions:
//   - SR: {MSB_in, A[W-1:1]}
//   - SL: {A[W-2:0], LSB_in}
//   - RR: {A[0], A[W-1:1]}
//   - RL: {A[W-2:0], A[W-1]}
//   - ASR: {A[W-1], A[W-1:1]}
//  Abort:
//   - Abort in RUN at an edge: no step on that edge, go to IDLE, done is not pulsed, A_par is held.
//   - Abort wins over a simultaneous final step.
//   - Abort in IDLE is ignored; a simultaneous valid command is accepted normally.
//  Other rules:
//   - cmd_valid while busy is ignored (not queued).
//   - Hold mode accepts and completes, leaving A_par unchanged.
// CONFIGURATION
//  UNIV_SR_PARITY_EN defined:
//   - Adds output port parity (1 bit) = ^A_par, combinational; it is 0 while reset holds A_par at 0.
//  UNIV_SR_PARITY_EN undefined:
//   - The parity port and its logic are absent; all other behaviour is identical.
// TESTING (WIDTH=8, CNT_W=4)
//  1 Clr_b low mid-stream -> A_par=00, cmd_ready=1, busy=0, done=0 immediately, without waiting for a clock edge.
//  2 load, I_par=A5 -> A_par=A5 after the accept edge; done high 1 cycle; cmd_ready never drops.
//  3 from A5, SR count 3, MSB_in=1 -> A_par D2, E9, F4 on successive edges; busy for 2 cycles; done in cycle 4.
//  4 from 80, ASR count 2 -> C0, E0; then RL count 12 (clamped to 8) -> E0 after 8 steps, done in cycle 9.
//  5 from 01, RR count 5, abort asserted at the 3rd edge -> A_par stays 40, no done, cmd_ready=1 next cycle.
//  6 Clr_b pulsed low during RUN of a SL count 6 -> A_par=00 and IDLE at once; count 0 command then -> A_par unchanged, done next cycle.

Source files
------------

// File: rtl/univ_shift_reg_seq.sv
// ============================================================================
// univ_shift_reg_seq : universal shift register with command handshake and
//                      multi-step shift/rotate sequencer.
// Optional feature macro: UNIV_SR_PARITY_EN (adds parity output = ^A_par)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             Clr_b,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] I_par,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic             abort,
    output logic [WIDTH-1:0] A_par,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
`ifdef UNIV_SR_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SR   = 3'b001;
    localparam logic [2:0] MODE_SL   = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_RR   = 3'b100;
    localparam logic [2:0] MODE_RL   = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       run_mode;
    logic [CNT_W-1:0] eff_count;
    logic [WIDTH-1:0] step_idle;
    logic [WIDTH-1:0] step_run;

    // One single-bit move of the register for the given shift/rotate mode.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] a,
        input logic             msb,
        input logic             lsb
    );
        logic [WIDTH-1:0] r;
        r = a;
        case (mode)
            MODE_SR:  r = {msb, a[WIDTH-1:1]};
            MODE_SL:  r = {a[WIDTH-2:0], lsb};
            MODE_RR:  r = {a[0], a[WIDTH-1:1]};
            MODE_RL:  r = {a[WIDTH-2:0], a[WIDTH-1]};
            MODE_ASR: r = {a[WIDTH-1], a[WIDTH-1:1]};
            default:  r = a;
        endcase
        return r;
    endfunction

    assign eff_count = (cmd_count > WIDTH_CNT) ? WIDTH_CNT : cmd_count;
    assign step_idle = step_fn(cmd_mode, A_par, MSB_in, LSB_in);
    assign step_run  = step_fn(run_mode, A_par, MSB_in, LSB_in);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == RUN);
    assign sout_r    = A_par[0];
    assign sout_l    = A_par[WIDTH-1];

`ifdef UNIV_SR_PARITY_EN
    assign parity = ^A_par;
`endif

    always_ff @(posedge CLK or negedge Clr_b) begin
        if (!Clr_b) begin
            state     <= IDLE;
            A_par     <= '0;
            remaining <= '0;
            run_mode  <= MODE_HOLD;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is deliberately not looked at here: it only cancels a running command
                    if (cmd_valid) begin
                        case (cmd_mode)
                            MODE_HOLD: done <= 1'b1;
                            MODE_LOAD: begin
                                A_par <= I_par;
                                done  <= 1'b1;
                            end
                            MODE_CLR: begin
                                A_par <= '0;
                                done  <= 1'b1;
                            end
                            default: begin
                                if (eff_count == '0) begin
                                    done <= 1'b1;
                                end else if (eff_count == CNT_W'(1)) begin
                                    A_par <= step_idle;
                                    done  <= 1'b1;
                                end else begin
                                    A_par     <= step_idle;
                                    remaining <= eff_count - CNT_W'(1);
                                    run_mode  <= cmd_mode;
                                    state     <= RUN;
                                end
                            end
                        endcase
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        remaining <= '0;
                    end else begin
                        A_par     <= step_run;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg_seq.sv
// ============================================================================
// tb_univ_shift_reg_seq : directed self-checking bench for univ_shift_reg_seq
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             Clr_b;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] I_par;
    logic             MSB_in;
    logic             LSB_in;
    logic             abort;
    logic [WIDTH-1:0] A_par;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;
`ifdef UNIV_SR_PARITY_EN
    logic             parity;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    univ_shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .Clr_b     (Clr_b),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .I_par     (I_par),
        .MSB_in    (MSB_in),
        .LSB_in    (LSB_in),
        .abort     (abort),
        .A_par     (A_par),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .busy      (busy),
        .done      (done)
`ifdef UNIV_SR_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    always #5 CLK = ~CLK;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a command for exactly one accept edge.
    task automatic send(input logic [2:0] mode, input logic [CNT_W-1:0] cnt,
                        input logic [WIDTH-1:0] par);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_count = cnt;
        I_par     = par;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        Clr_b = 1'b0; cmd_valid = 1'b0; cmd_mode = 3'b000; cmd_count = '0;
        I_par = '0; MSB_in = 1'b0; LSB_in = 1'b0; abort = 1'b0;
        #1;
        n_cmp++; if (A_par !== 8'h00) begin n_fail++; $display("FAIL reset_a: A_par=%h exp=00", A_par); end
        n_cmp++; if ({cmd_ready, busy, done} !== 3'b100) begin n_fail++; $display("FAIL reset_flags: rdy/busy/done=%b exp=100", {cmd_ready, busy, done}); end
        tick(); tick();
        Clr_b = 1'b1;
        tick();
        // Load, then reset asynchronously while done is high.
        send(3'b011, 4'd0, 8'h3C);
        n_cmp++; if ({A_par, done} !== {8'h3C, 1'b1}) begin n_fail++; $display("FAIL pre_reset_load: A_par/done=%h/%b exp=3c/1", A_par, done); end
        #2 Clr_b = 1'b0;
        #1;
        n_cmp++; if ({A_par, cmd_ready, busy, done} !== {8'h00, 3'b100}) begin n_fail++; $display("FAIL async_reset: A_par=%h rdy/busy/done=%b exp=00 100", A_par, {cmd_ready, busy, done}); end
        #2 Clr_b = 1'b1;
        tick();
    endtask

    task automatic test_load();
        send(3'b011, 4'd5, 8'hA5);
        n_cmp++; if ({A_par, done, cmd_ready} !== {8'hA5, 2'b11}) begin n_fail++; $display("FAIL load: A_par/done/rdy=%h/%b%b exp=a5/11", A_par, done, cmd_ready); end
        n_cmp++; if ({sout_l, sout_r} !== 2'b11) begin n_fail++; $display("FAIL load_sout: sout_l/r=%b exp=11", {sout_l, sout_r}); end
        tick();
        n_cmp++; if ({A_par, done, cmd_ready} !== {8'hA5, 2'b01}) begin n_fail++; $display("FAIL load_after: A_par/done/rdy=%h/%b%b exp=a5/01", A_par, done, cmd_ready); end
    endtask

    task automatic test_shift_right();
        MSB_in = 1'b1;
        send(3'b001, 4'd3, 8'h00);
        n_cmp++; if ({A_par, busy, done} !== {8'hD2, 2'b10}) begin n_fail++; $display("FAIL sr_e1: A_par/busy/done=%h/%b exp=d2/10", A_par, {busy, done}); end
        // A command offered while busy must be dropped.
        cmd_valid = 1'b1; cmd_mode = 3'b011; I_par = 8'h00;
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if ({A_par, busy, done} !== {8'hE9, 2'b10}) begin n_fail++; $display("FAIL sr_e2: A_par/busy/done=%h/%b exp=e9/10", A_par, {busy, done}); end
        tick();
        n_cmp++; if ({A_par, busy, done, cmd_ready} !== {8'hF4, 3'b011}) begin n_fail++; $display("FAIL sr_e3: A_par/busy/done/rdy=%h/%b exp=f4/011", A_par, {busy, done, cmd_ready}); end
`ifdef UNIV_SR_PARITY_EN
        n_cmp++; if (parity !== 1'b1) begin n_fail++; $display("FAIL parity: parity=%b exp=1", parity); end
`endif
        tick();
        n_cmp++; if ({A_par, done} !== {8'hF4, 1'b0}) begin n_fail++; $display("FAIL sr_after: A_par/done=%h/%b exp=f4/0", A_par, done); end
        MSB_in = 1'b0;
    endtask

    task automatic test_asr_rotate();
        send(3'b011, 4'd0, 8'h80);
        tick();
        send(3'b110, 4'd2, 8'h00);
        n_cmp++; if (A_par !== 8'hC0) begin n_fail++; $display("FAIL asr_e1: A_par=%h exp=c0", A_par); end
        tick();
        n_cmp++; if ({A_par, done} !== {8'hE0, 1'b1}) begin n_fail++; $display("FAIL asr_e2: A_par/done=%h/%b exp=e0/1", A_par, done); end
        // Back-to-back: accepted in the cycle done is high; count 12 clamps to 8.
        send(3'b101, 4'd12, 8'h00);
        n_cmp++; if ({A_par, busy} !== {8'hC1, 1'b1}) begin n_fail++; $display("FAIL rl_e1: A_par/busy=%h/%b exp=c1/1", A_par, busy); end
        for (int i = 2; i <= 7; i++) tick();
        n_cmp++; if ({A_par, busy, done} !== {8'h70, 2'b10}) begin n_fail++; $display("FAIL rl_e7: A_par/busy/done=%h/%b exp=70/10", A_par, {busy, done}); end
        tick();
        n_cmp++; if ({A_par, busy, done} !== {8'hE0, 2'b01}) begin n_fail++; $display("FAIL rl_e8: A_par/busy/done=%h/%b exp=e0/01", A_par, {busy, done}); end
        tick();
    endtask

    task automatic test_abort();
        send(3'b011, 4'd0, 8'h01);
        tick();
        send(3'b100, 4'd5, 8'h00);
        n_cmp++; if (A_par !== 8'h80) begin n_fail++; $display("FAIL rr_e1: A_par=%h exp=80", A_par); end
        tick();
        n_cmp++; if (A_par !== 8'h40) begin n_fail++; $display("FAIL rr_e2: A_par=%h exp=40", A_par); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if ({A_par, cmd_ready, busy, done} !== {8'h40, 3'b100}) begin n_fail++; $display("FAIL abort: A_par=%h rdy/busy/done=%b exp=40 100", A_par, {cmd_ready, busy, done}); end
        tick();
        n_cmp++; if ({A_par, done} !== {8'h40, 1'b0}) begin n_fail++; $display("FAIL abort_after: A_par/done=%h/%b exp=40/0", A_par, done); end
        // Abort while idle does not block a valid command.
        abort = 1'b1;
        send(3'b011, 4'd0, 8'h3C);
        abort = 1'b0;
        n_cmp++; if ({A_par, done} !== {8'h3C, 1'b1}) begin n_fail++; $display("FAIL abort_idle: A_par/done=%h/%b exp=3c/1", A_par, done); end
        tick();
        // Abort on the would-be final step wins.
        send(3'b100, 4'd2, 8'h00);
        n_cmp++; if (A_par !== 8'h1E) begin n_fail++; $display("FAIL rr2_e1: A_par=%h exp=1e", A_par); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if ({A_par, busy, done} !== {8'h1E, 2'b00}) begin n_fail++; $display("FAIL abort_final: A_par/busy/done=%h/%b exp=1e/00", A_par, {busy, done}); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_final_done: done=%b exp=0", done); end
    endtask

    task automatic test_hold_clear();
        send(3'b000, 4'd7, 8'hFF);
        n_cmp++; if ({A_par, done} !== {8'h1E, 1'b1}) begin n_fail++; $display("FAIL hold: A_par/done=%h/%b exp=1e/1", A_par, done); end
        send(3'b111, 4'd0, 8'hFF);
        n_cmp++; if ({A_par, done} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL clear: A_par/done=%h/%b exp=00/1", A_par, done); end
        tick();
    endtask

    task automatic test_reset_in_run();
        send(3'b011, 4'd0, 8'hFF);
        tick();
        LSB_in = 1'b0;
        send(3'b010, 4'd6, 8'h00);
        n_cmp++; if ({A_par, busy} !== {8'hFE, 1'b1}) begin n_fail++; $display("FAIL sl_e1: A_par/busy=%h/%b exp=fe/1", A_par, busy); end
        tick();
        n_cmp++; if ({A_par, busy} !== {8'hFC, 1'b1}) begin n_fail++; $display("FAIL sl_e2: A_par/busy=%h/%b exp=fc/1", A_par, busy); end
        #2 Clr_b = 1'b0;
        #1;
        n_cmp++; if ({A_par, cmd_ready, busy, done} !== {8'h00, 3'b100}) begin n_fail++; $display("FAIL run_reset: A_par=%h rdy/busy/done=%b exp=00 100", A_par, {cmd_ready, busy, done}); end
        #2 Clr_b = 1'b1;
        tick();
        n_cmp++; if ({A_par, busy} !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL run_reset_hold: A_par/busy=%h/%b exp=00/0", A_par, busy); end
        send(3'b011, 4'd0, 8'h5A);
        tick();
        MSB_in = 1'b1;
        send(3'b001, 4'd0, 8'h00);
        n_cmp++; if ({A_par, done, busy} !== {8'h5A, 2'b10}) begin n_fail++; $display("FAIL count0: A_par/done/busy=%h/%b exp=5a/10", A_par, {done, busy}); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL count0_after: done=%b exp=0", done); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_right();
        test_asr_rotate();
        test_abort();
        test_hold_clear();
        test_reset_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
